// File: rtl/regfile.sv
`default_nettype none
// ============================================================================
//  Module   : regfile
//  Purpose  : 32 x WIDTH integer register file, one write port and two
//             combinational read ports, r0 hardwired to zero, optional bypass.
//  Revision : 1.0  initial release
// ============================================================================
module regfile #(
  parameter int WIDTH  = 32,
  parameter bit BYPASS = 1'b1
) (
  input  logic             clock,
  input  logic             ctrl_reset,
  input  logic             ctrl_writeEnable,
  input  logic [4:0]       ctrl_writeReg,
  input  logic [4:0]       ctrl_readRegA,
  input  logic [4:0]       ctrl_readRegB,
  input  logic [WIDTH-1:0] data_writeReg,
  output logic [WIDTH-1:0] data_readRegA,
  output logic [WIDTH-1:0] data_readRegB
);

  localparam int c_NUM_REGS = 32;

  logic [c_NUM_REGS-1:0] w_write_en;
  logic [WIDTH-1:0]      r_regs   [1:c_NUM_REGS-1];
  logic [WIDTH-1:0]      w_values [0:c_NUM_REGS-1];

  // One-hot write decode; bit 0 is forced low so r0 can never be written or bypassed.
  always_comb begin
    w_write_en = '0;
    if (ctrl_writeEnable) begin
      w_write_en[ctrl_writeReg] = 1'b1;
    end
    w_write_en[0] = 1'b0;
  end

  assign w_values[0] = '0;

  generate
    for (genvar i = 1; i < c_NUM_REGS; i++) begin : g_regs
      always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
          r_regs[i] <= '0;
        end else if (w_write_en[i]) begin
          r_regs[i] <= data_writeReg;
        end
      end
      assign w_values[i] = r_regs[i];
    end
  endgenerate

  always_comb begin
    data_readRegA = w_values[ctrl_readRegA];
    if (ctrl_reset) begin
      data_readRegA = '0;
    end else if (BYPASS && w_write_en[ctrl_readRegA]) begin
      data_readRegA = data_writeReg;
    end
  end

  always_comb begin
    data_readRegB = w_values[ctrl_readRegB];
    if (ctrl_reset) begin
      data_readRegB = '0;
    end else if (BYPASS && w_write_en[ctrl_readRegB]) begin
      data_readRegB = data_writeReg;
    end
  end

endmodule
`default_nettype wire
